// File: rtl/nmed_pkg.sv
// Shared types and helpers for the exhaustive approximate-multiplier error sweep.
// Width helpers keep product and accumulator sizing consistent across files.
package nmed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest product abs_diff supports; callers zero-extend into it.
  localparam int ABS_W = 32;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  function automatic int sum_width(input int width);
    return 4 * width;
  endfunction

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/nmed_delay_line.sv
// Fixed-depth register pipeline that keeps issued operands aligned with the
// multiplier-under-test latency; DEPTH = 0 degenerates to a plain wire.
module nmed_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '{default: '0};
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/nmed_sweep_engine.sv
// Drives every WIDTH x WIDTH operand pair into an external multiplier and
// accumulates |ED| sum, max |ED| with its operands, and erroneous-result count.
module nmed_sweep_engine
  import nmed_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [WIDTH-1:0]                o_a,
  output logic [WIDTH-1:0]                o_b,
  input  logic [prod_width(WIDTH)-1:0]    i_z,
  output logic [sum_width(WIDTH)-1:0]     o_sum_ed,
  output logic [prod_width(WIDTH)-1:0]    o_max_ed,
  output logic [prod_width(WIDTH):0]      o_err_count,
  output logic [WIDTH-1:0]                o_max_a,
  output logic [WIDTH-1:0]                o_max_b
);

  localparam int PW  = prod_width(WIDTH);
  localparam int SW  = sum_width(WIDTH);
  localparam int CW  = PW + 1;
  localparam int DLW = 1 + PW + 2 * WIDTH;
  localparam int DW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [PW-1:0] IDX_LAST = '1;

  state_t           state_q, state_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] max_a_q, max_a_d;
  logic [WIDTH-1:0] max_b_q, max_b_d;

  logic             issue_v;
  logic [PW-1:0]    issue_exact;
  logic             ret_v;
  logic [PW-1:0]    ret_exact;
  logic [WIDTH-1:0] ret_a;
  logic [WIDTH-1:0] ret_b;
  logic [PW-1:0]    ed;
  logic             ed_nz;

  // The index register doubles as the operand source, so o_a/o_b naturally
  // hold their last value whenever the sweep is not advancing.
  assign o_a         = idx_q[PW-1:WIDTH];
  assign o_b         = idx_q[WIDTH-1:0];
  assign issue_v     = (state_q == SWEEP);
  assign issue_exact = {{WIDTH{1'b0}}, o_a} * {{WIDTH{1'b0}}, o_b};

  nmed_delay_line #(
    .W     (DLW),
    .DEPTH (LATENCY)
  ) u_align (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    ({issue_v, issue_exact, o_a, o_b}),
    .q_o    ({ret_v, ret_exact, ret_a, ret_b})
  );

  assign ed    = PW'(abs_diff(ABS_W'(ret_exact), ABS_W'(i_z)));
  assign ed_nz = (ed != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    sum_d   = sum_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    max_a_d = max_a_q;
    max_b_d = max_b_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SWEEP;
          idx_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          max_a_d = '0;
          max_b_d = '0;
        end
      end
      SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = (LATENCY > 0) ? DRAIN : DONE;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(LATENCY - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strict compare so the earliest pair wins a tie on max |ED|.
    if (ret_v) begin
      sum_d = sum_q + SW'(ed);
      cnt_d = cnt_q + CW'(ed_nz);
      if (ed > max_q) begin
        max_d   = ed;
        max_a_d = ret_a;
        max_b_d = ret_b;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      max_a_q <= max_a_d;
      max_b_q <= max_b_d;
    end
  end

  assign o_busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign o_done      = (state_q == DONE);
  assign o_sum_ed    = sum_q;
  assign o_max_ed    = max_q;
  assign o_err_count = cnt_q;
  assign o_max_a     = max_a_q;
  assign o_max_b     = max_b_q;

endmodule

// File: tb/tb_nmed_sweep_engine.sv
// Bench for nmed_sweep_engine: three WIDTH=4 instances at latencies 0, 2 and 1,
// each fed by a behavioural faulty multiplier, checked against exhaustive loops.
module tb_nmed_sweep_engine;

  localparam int NDUT  = 3;
  localparam int NPAIR = 256;
  localparam int LIMIT = NPAIR + 12;
  localparam int NVEC  = 8;

  localparam int F_BUSY = 0, F_DONE = 1, F_A = 2, F_B = 3, F_SUM = 4;
  localparam int F_MAX = 5, F_CNT = 6, F_MA = 7, F_MB = 8;

  typedef struct {
    int dut;
    int mode;
    int inj;
    int dpulse;
    int rst_at;
    int e_sum;
    int e_max;
    int e_cnt;
    int e_ma;
    int e_mb;
    int e_done;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_s [NDUT];
  logic       busy_s  [NDUT];
  logic       done_s  [NDUT];
  logic [3:0] a_s     [NDUT];
  logic [3:0] b_s     [NDUT];
  logic [3:0] ma_s    [NDUT];
  logic [3:0] mb_s    [NDUT];
  logic [7:0] max_s   [NDUT];
  logic [15:0] sum_s  [NDUT];
  logic [8:0] cnt_s   [NDUT];
  logic [7:0] z0, z1, z1_p, z2;
  int         mode_s  [NDUT];
  logic [7:0] tab     [NDUT][NPAIR];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  // Multiplier under test: 0 exact, 1 LSB flip, 2 single bad pair,
  // 3 +2, 4 table lookup, 5 -3 (wrapping in 8 bits).
  function automatic logic [7:0] fault_z(input int mode, input logic [3:0] a,
                                         input logic [3:0] b, input logic [7:0] tv);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (mode)
      1:       return p ^ 8'd1;
      2:       return (a == 4'd12 && b == 4'd10) ? 8'd125 : p;
      3:       return p + 8'd2;
      4:       return tv;
      5:       return p - 8'd3;
      default: return p;
    endcase
  endfunction

  always_comb z0 = fault_z(mode_s[0], a_s[0], b_s[0], tab[0][{a_s[0], b_s[0]}]);

  always @(posedge clk) begin
    z1_p <= fault_z(mode_s[1], a_s[1], b_s[1], tab[1][{a_s[1], b_s[1]}]);
    z1   <= z1_p;
    z2   <= fault_z(mode_s[2], a_s[2], b_s[2], tab[2][{a_s[2], b_s[2]}]);
  end

  nmed_sweep_engine #(.WIDTH(4), .LATENCY(0)) u_l0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[0]), .o_busy(busy_s[0]),
    .o_done(done_s[0]), .o_a(a_s[0]), .o_b(b_s[0]), .i_z(z0),
    .o_sum_ed(sum_s[0]), .o_max_ed(max_s[0]), .o_err_count(cnt_s[0]),
    .o_max_a(ma_s[0]), .o_max_b(mb_s[0]));

  nmed_sweep_engine #(.WIDTH(4), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[1]), .o_busy(busy_s[1]),
    .o_done(done_s[1]), .o_a(a_s[1]), .o_b(b_s[1]), .i_z(z1),
    .o_sum_ed(sum_s[1]), .o_max_ed(max_s[1]), .o_err_count(cnt_s[1]),
    .o_max_a(ma_s[1]), .o_max_b(mb_s[1]));

  nmed_sweep_engine #(.WIDTH(4), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[2]), .o_busy(busy_s[2]),
    .o_done(done_s[2]), .o_a(a_s[2]), .o_b(b_s[2]), .i_z(z2),
    .o_sum_ed(sum_s[2]), .o_max_ed(max_s[2]), .o_err_count(cnt_s[2]),
    .o_max_a(ma_s[2]), .o_max_b(mb_s[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic int peek(input int d, input int f);
    case (f)
      F_BUSY:  return int'(busy_s[d]);
      F_DONE:  return int'(done_s[d]);
      F_A:     return int'(a_s[d]);
      F_B:     return int'(b_s[d]);
      F_SUM:   return int'(sum_s[d]);
      F_MAX:   return int'(max_s[d]);
      F_CNT:   return int'(cnt_s[d]);
      F_MA:    return int'(ma_s[d]);
      F_MB:    return int'(mb_s[d]);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_all_zero(input string tag, input int d);
    string names [9];
    names = '{"busy", "done", "a", "b", "sum", "max", "cnt", "max_a", "max_b"};
    for (int f = 0; f < 9; f++) begin
      chk($sformatf("%s dut%0d %s", tag, d, names[f]), peek(d, f), 0);
    end
  endtask

  // Reference: walk every pair in issue order using plain arithmetic.
  task automatic model(input int d, input int mode, output int s, output int mx,
                       output int cnt, output int ma, output int mb);
    s = 0; mx = 0; cnt = 0; ma = 0; mb = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int p, z, e;
        p = a * b;
        z = int'(fault_z(mode, a[3:0], b[3:0], tab[d][a*16+b]));
        e = (p > z) ? p - z : z - p;
        s += e;
        if (e != 0) cnt++;
        if (e > mx) begin
          mx = e; ma = a; mb = b;
        end
      end
    end
  endtask

  task automatic run_case(input int d, input int mode, input int inj, input int dpulse,
                          input int rst_at, output int done_cyc, output int busy_cyc,
                          output int pulses, output int seq_err);
    int cyc;
    done_cyc = -1; busy_cyc = 0; pulses = 0; seq_err = 0;
    mode_s[d] = mode;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    cyc = 1;
    while (cyc <= LIMIT) begin
      if (peek(d, F_BUSY) != 0) busy_cyc++;
      if (peek(d, F_DONE) != 0) begin
        pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc <= NPAIR) begin
        if (peek(d, F_BUSY) == 0 || peek(d, F_A) * 16 + peek(d, F_B) != cyc - 1) seq_err++;
      end
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid", d);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_s[d] = ((inj >= 0 && cyc == inj + 1) || (dpulse != 0 && peek(d, F_DONE) != 0));
      @(negedge clk);
      cyc++;
    end
    start_s[d] = 1'b0;
  endtask

  task automatic check_results(input string tag, input int d, input int dc, input int bc,
                               input int pc, input int se, input int e_sum, input int e_max,
                               input int e_cnt, input int e_ma, input int e_mb, input int e_done);
    $display("%s dut%0d: sum=%0d max=%0d cnt=%0d max_a=%0d max_b=%0d done@%0d busy=%0d",
             tag, d, peek(d, F_SUM), peek(d, F_MAX), peek(d, F_CNT), peek(d, F_MA),
             peek(d, F_MB), dc, bc);
    chk({tag, " sum"},       peek(d, F_SUM), e_sum);
    chk({tag, " max"},       peek(d, F_MAX), e_max);
    chk({tag, " cnt"},       peek(d, F_CNT), e_cnt);
    chk({tag, " max_a"},     peek(d, F_MA),  e_ma);
    chk({tag, " max_b"},     peek(d, F_MB),  e_mb);
    chk({tag, " done_cyc"},  dc, e_done);
    chk({tag, " busy_cyc"},  bc, e_done - 1);
    chk({tag, " done_pulses"}, pc, 1);
    chk({tag, " idx_seq_err"}, se, 0);
    chk({tag, " hold_a"},    peek(d, F_A), 15);
    chk({tag, " hold_b"},    peek(d, F_B), 15);
  endtask

  initial begin
    vec_t vecs [NVEC];
    int dc, bc, pc, se;
    int m_sum, m_max, m_cnt, m_ma, m_mb;
    int d, p, off;

    for (int k = 0; k < NDUT; k++) begin
      start_s[k] = 1'b0;
      mode_s[k]  = 0;
      for (int i = 0; i < NPAIR; i++) tab[k][i] = 8'd0;
    end

    //          dut mode inj dp rst   sum  max  cnt ma  mb  done
    vecs[0] = '{0,  0,   -1, 0, -1,   0,    0,   0,  0,  0, 257};
    vecs[1] = '{0,  1,   -1, 0, -1,   256,  1,   256, 0, 0, 257};
    vecs[2] = '{1,  2,   -1, 0, -1,   5,    5,   1,  12, 10, 259};
    vecs[3] = '{2,  3,   -1, 0, -1,   512,  2,   256, 0, 0, 258};
    vecs[4] = '{0,  1,   -1, 0, 100,  0,    0,   0,  0,  0, 0};
    vecs[5] = '{0,  0,   -1, 0, -1,   0,    0,   0,  0,  0, 257};
    vecs[6] = '{0,  1,   50, 1, -1,   256,  1,   256, 0, 0, 257};
    vecs[7] = '{0,  5,   -1, 0, -1,   9268, 253, 256, 0, 0, 257};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk_all_zero("reset", k);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_case(vecs[i].dut, vecs[i].mode, vecs[i].inj, vecs[i].dpulse, vecs[i].rst_at,
               dc, bc, pc, se);
      if (vecs[i].rst_at < 0) begin
        check_results($sformatf("vec%0d", i), vecs[i].dut, dc, bc, pc, se,
                      vecs[i].e_sum, vecs[i].e_max, vecs[i].e_cnt, vecs[i].e_ma,
                      vecs[i].e_mb, vecs[i].e_done);
      end else begin
        $display("vec%0d dut%0d: reset asserted at idx %0d", i, vecs[i].dut, vecs[i].rst_at);
      end
    end

    // Randomised product tables; even rounds use small offsets to provoke max ties.
    for (int r = 0; r < 6; r++) begin
      d = r % NDUT;
      for (int i = 0; i < NPAIR; i++) begin
        p = (i / 16) * (i % 16);
        if (r % 2 == 0) begin
          off = int'($urandom_range(0, 4)) - 2;
          tab[d][i] = 8'(p + off);
        end else begin
          tab[d][i] = ($urandom_range(0, 3) != 0) ? 8'(p) : 8'($urandom_range(0, 255));
        end
      end
      model(d, 4, m_sum, m_max, m_cnt, m_ma, m_mb);
      run_case(d, 4, -1, 0, -1, dc, bc, pc, se);
      check_results($sformatf("rand%0d", r), d, dc, bc, pc, se,
                    m_sum, m_max, m_cnt, m_ma, m_mb, NPAIR + 1 + lat_of(d));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
